// File: rtl/traffic_pkg.sv
// Shared traffic-light constants: phase timer width and limits.
// Reused by the controller and by its phase counter.
package traffic_pkg;

  localparam int TR_CNT_W       = 6;
  localparam int TR_LONG_LIMIT  = 25;
  localparam int TR_SHORT_LIMIT = 4;

  function automatic bit limit_fits(input int lim, input int w);
    return (lim >= 0) && (lim <= ((1 << w) - 1));
  endfunction

endpackage

// File: rtl/counter.sv
// Phase timer: counts up to the selected limit, then latches over_flag.
// Only reset clears the flag; the parent loops it back into reset.
module counter
  import traffic_pkg::*;
#(
  parameter int CNT_W       = TR_CNT_W,
  parameter int LONG_LIMIT  = TR_LONG_LIMIT,
  parameter int SHORT_LIMIT = TR_SHORT_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_compare,
  output logic [CNT_W-1:0] cnt,
  output logic             over_flag
);

  localparam logic [CNT_W-1:0] LP_LONG  = CNT_W'(LONG_LIMIT);
  localparam logic [CNT_W-1:0] LP_SHORT = CNT_W'(SHORT_LIMIT);

  if (!limit_fits(LONG_LIMIT, CNT_W) ||
      !limit_fits(SHORT_LIMIT, CNT_W)) begin : g_bad_limit
    $error("counter: limit does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_over;
  logic [CNT_W-1:0] w_limit;

  assign w_limit = sel_compare ? LP_LONG : LP_SHORT;

  // >= so a mid-count drop to the short limit flags instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_over <= 1'b0;
    end else if (!r_over) begin
      if (r_cnt < w_limit) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_over <= 1'b1;
      end
    end
  end

  assign cnt       = r_cnt;
  assign over_flag = r_over;

endmodule

// File: tb/tb_counter.sv
// Scoreboarded bench for the phase counter.
// Stimulus queues expected outputs; a monitor pops and compares them.
module tb_counter;

  typedef struct {
    string      nm;
    logic [5:0] c;
    logic       f;
  } exp_t;

  logic       clk;
  logic       ext_rst;
  logic       loop_en;
  logic       rst_w;
  logic       sel_compare;
  logic [5:0] cnt;
  logic       over_flag;

  exp_t q[$];
  event ev_s;
  int   nvec;
  int   errs;

  assign rst_w = ext_rst | (loop_en & over_flag);

  counter dut (
    .clk        (clk),
    .reset      (rst_w),
    .sel_compare(sel_compare),
    .cnt        (cnt),
    .over_flag  (over_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    errs = 0;
    forever begin
      @(ev_s);
      nvec++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL monitor: no expectation queued, got cnt=%0d flag=%0b",
                 cnt, over_flag);
      end else begin
        automatic exp_t e = q.pop_front();
        if (cnt !== e.c || over_flag !== e.f) begin
          errs++;
          $display("FAIL %s: got cnt=%0d flag=%0b required cnt=%0d flag=%0b",
                   e.nm, cnt, over_flag, e.c, e.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [5:0] c, input logic f);
    exp_t e;
    e.nm = nm;
    e.c  = c;
    e.f  = f;
    q.push_back(e);
    ->ev_s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic sel);
    @(negedge clk);
    ext_rst     = 1'b1;
    sel_compare = sel;
    #1;
    chk("rst_async", 6'd0, 1'b0);
    @(negedge clk);
    ext_rst = 1'b0;
  endtask

  initial begin
    ext_rst     = 1'b1;
    loop_en     = 1'b0;
    sel_compare = 1'b1;

    // long phase from reset
    tick();
    chk("rst_hold1", 6'd0, 1'b0);
    tick();
    chk("rst_hold2", 6'd0, 1'b0);
    @(negedge clk);
    ext_rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk($sformatf("long_e%0d", i), 6'(i), 1'b0);
    end
    tick();
    chk("long_over", 6'd25, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("long_hold", 6'd25, 1'b1);
    end

    // reset pulse between edges while flagged
    @(negedge clk);
    ext_rst = 1'b1;
    #1;
    chk("pulse_clr", 6'd0, 1'b0);
    ext_rst = 1'b0;
    tick();
    chk("pulse_next", 6'd1, 1'b0);

    // short phase
    restart(1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("short_e%0d", i), 6'(i), 1'b0);
    end
    tick();
    chk("short_over", 6'd4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("short_hold", 6'd4, 1'b1);
    end

    // limit drops below count mid-phase
    restart(1'b1);
    for (int i = 1; i <= 10; i++) tick();
    chk("sw_at10", 6'd10, 1'b0);
    sel_compare = 1'b0;
    tick();
    chk("sw_over", 6'd10, 1'b1);
    tick();
    chk("sw_hold", 6'd10, 1'b1);

    // reset coincident with a clock edge
    restart(1'b1);
    for (int i = 1; i <= 12; i++) tick();
    chk("co_at12", 6'd12, 1'b0);
    @(posedge clk);
    ext_rst = 1'b1;
    #1;
    chk("co_edge", 6'd0, 1'b0);
    @(negedge clk);
    ext_rst = 1'b0;
    tick();
    chk("co_resume", 6'd1, 1'b0);

    // flag looped into reset: free-running period of 26 edges
    restart(1'b1);
    loop_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 25; i++) begin
        tick();
        chk($sformatf("loop%0d_e%0d", p, i), 6'(i), 1'b0);
      end
      tick();
      chk($sformatf("loop%0d_wrap", p), 6'd0, 1'b0);
    end
    tick();
    chk("loop_restart", 6'd1, 1'b0);
    loop_en = 1'b0;

    #2;
    nvec++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: CNT_W, default 6, width of cnt.
REQ-002 Parameter: LONG_LIMIT, default 25, terminal count when sel_compare=1 (green phases).
REQ-003 Parameter: SHORT_LIMIT, default 4, terminal count when sel_compare=0 (yellow phases).
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-006 Port: sel_compare  input  1  limit select: 1 = LONG_LIMIT, 0 = SHORT_LIMIT.
REQ-007 Port: cnt  output  CNT_W  current count value, registered.
REQ-008 Port: over_flag  output  1  terminal-count flag, registered.
REQ-009 The block SHALL use one clock (clk) and an asynchronous active-high reset (reset).

Function
REQ-010 The active limit L SHALL be LONG_LIMIT when sel_compare=1, else SHORT_LIMIT, sampled combinationally each cycle.
REQ-011 On a rising clk edge with over_flag=0 and cnt < L, cnt SHALL increment by 1.
REQ-012 On a rising clk edge with over_flag=0 and cnt >= L, over_flag SHALL be set to 1 and cnt SHALL hold.
REQ-013 While over_flag=1 and reset=0, cnt and over_flag SHALL hold their values; only reset clears the flag.
REQ-014 If sel_compare changes mid-count so that cnt already exceeds the new L, over_flag SHALL be set on the next rising edge (no wrap, no extra counting).
REQ-015 cnt SHALL never wrap; increment never exceeds L, so cnt <= max(LONG_LIMIT, SHORT_LIMIT).
REQ-016 Both limits SHALL be <= 2^CNT_W - 1; out-of-range parameters are an elaboration error.
REQ-017 With sel_compare held constant after reset, over_flag SHALL rise on the (L+1)-th rising edge after reset deasserts.
REQ-018 over_flag SHALL be glitch-free (flop output) because the parent ORs it into this block's reset and uses its falling edge as a clock.

Reset
REQ-019 While reset=1, cnt SHALL be 0 and over_flag SHALL be 0, immediately and regardless of clk.
REQ-020 Reset asserted mid-count or while over_flag=1 SHALL clear both outputs asynchronously; counting resumes from 0 on the first rising edge after deassertion.
REQ-021 Reset and clk edge coinciding: reset SHALL win.

Structure
REQ-022 CNT_W, LONG_LIMIT and SHORT_LIMIT default values SHALL live in the shared traffic package, reused by the traffic-light controller.
REQ-023 The block SHALL be a single flat module; no sub-module is needed.

Verification
REQ-024 Assert reset for 2 cycles, release with sel_compare=1 -> cnt=0, over_flag=0 during reset; cnt=1..25 on edges 1..25; over_flag=1 on edge 26 with cnt=25.
REQ-025 sel_compare=0 from reset -> cnt reaches 4 on edge 4; over_flag=1 on edge 5; cnt holds 4 for 10 further edges.
REQ-026 With over_flag=1, pulse reset between clk edges -> cnt=0, over_flag=0 immediately; next edge cnt=1.
REQ-027 sel_compare=1, count to 10, switch sel_compare=0 -> next edge over_flag=1, cnt stays 10.
REQ-028 Reset asserted at cnt=12 coincident with a rising clk edge -> cnt=0, over_flag=0, no increment.
REQ-029 Loop over_flag into reset (reset = ext_reset | over_flag) -> cnt cycles 0..25 repeatedly, over_flag single short pulse per period, never stuck high.
